// File: rtl/s2p_pkg.sv
// s2p_pkg: shared constants and FSM encoding for the s2p deserializer.
package s2p_pkg;
    localparam int BYTE_W = 8;
    localparam int LANES  = 4;
    localparam logic [BYTE_W-1:0] SYNC_BYTE   = 8'hBC;
    localparam logic [7:0]        SYNC_WINDOW = 8'd16;
    typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_e;
endpackage

// File: rtl/s2p_lane.sv
// s2p_lane: MSB-first serial shift register exposing the byte completed by the current bit.
module s2p_lane
    import s2p_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              bit_i,
    output logic [BYTE_W-1:0] byte_o
);
    // The oldest bit falls out of the byte window, so only seven bits need storage.
    logic [BYTE_W-2:0] sr_q;
    assign byte_o = {sr_q, bit_i};
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sr_q <= '0;
        else if (en_i) sr_q <= byte_o[BYTE_W-2:0];
    end
endmodule

// File: rtl/s2p.sv
// s2p: 4-lane serial-to-parallel deserializer with lane-0 sync byte alignment and lock tracking.
module s2p
    import s2p_pkg::*;
(
    input  logic       CLK,
    input  logic       reset,
    input  logic       ENB,
    input  logic [3:0] data_in,
    output logic [7:0] Q0,
    output logic [7:0] Q1,
    output logic [7:0] Q2,
    output logic [7:0] Q3,
    output logic       valid,
    output logic       locked
);
    logic [LANES-1:0][BYTE_W-1:0] b, q_q, q_d;
    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       valid_q, valid_d;
    logic       is_sync;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        s2p_lane u_lane (
            .clk_i (CLK),
            .rst_ni(reset),
            .en_i  (ENB),
            .bit_i (data_in[i]),
            .byte_o(b[i])
        );
    end
    assign is_sync = b[0] == SYNC_BYTE;
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        q_d         = q_q;
        valid_d     = 1'b0;
        if (ENB) begin
            if (state_q == ST_SEARCH) begin
                if (is_sync) begin
                    state_d     = ST_LOCKED;
                    bit_cnt_d   = 3'd0;
                    frame_cnt_d = 8'd0;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                // Frame boundary: sync refreshes the window, data is delivered until the window runs out.
                if (bit_cnt_q == 3'd7) begin
                    if (is_sync) begin
                        frame_cnt_d = 8'd0;
                    end else if (frame_cnt_q < SYNC_WINDOW) begin
                        q_d         = b;
                        valid_d     = 1'b1;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end
            end
        end
    end
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_SEARCH;
            bit_cnt_q   <= 3'd0;
            frame_cnt_q <= 8'd0;
            q_q         <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            q_q         <= q_d;
            valid_q     <= valid_d;
        end
    end
    assign Q0     = q_q[0];
    assign Q1     = q_q[1];
    assign Q2     = q_q[2];
    assign Q3     = q_q[3];
    assign valid  = valid_q;
    assign locked = state_q == ST_LOCKED;
endmodule

// File: tb/tb_s2p.sv
// tb_s2p: scoreboard bench for s2p; expected words are queued as frames are driven.
module tb_s2p;
    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       ENB = 1'b0;
    logic [3:0] data_in = 4'h0;
    logic [7:0] Q0, Q1, Q2, Q3;
    logic       valid, locked;

    s2p dut (
        .CLK    (CLK),
        .reset  (reset),
        .ENB    (ENB),
        .data_in(data_in),
        .Q0     (Q0),
        .Q1     (Q1),
        .Q2     (Q2),
        .Q3     (Q3),
        .valid  (valid),
        .locked (locked)
    );

    always #5 CLK = ~CLK;

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_valid = 0;
    logic        prev_valid = 1'b0;

    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b0;
        ENB = 1'b0;
        data_in = 4'h0;
        @(negedge CLK);
        reset = 1'b1;
        prev_valid = 1'b0;
        n_valid = 0;
        exp_q.delete();
    endtask

    // One clock: drive at negedge, sample 1 time unit after the posedge, score any valid pulse.
    task automatic step(input logic [3:0] d, input logic en);
        logic [31:0] w;
        @(negedge CLK);
        data_in = d;
        ENB = en;
        @(posedge CLK);
        #1;
        if (valid) begin
            n_valid++;
            n_cmp++;
            if (prev_valid) begin
                n_err++;
                $display("FAIL valid_back_to_back: valid=1 prev=1 required prev=0");
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: Q=%h required no valid", {Q3, Q2, Q1, Q0});
            end else begin
                w = exp_q.pop_front();
                if ({Q3, Q2, Q1, Q0} !== w) begin
                    n_err++;
                    $display("FAIL frame_data: Q=%h required %h", {Q3, Q2, Q1, Q0}, w);
                end
            end
        end
        prev_valid = valid;
    endtask

    task automatic send_frame(input logic [31:0] w, input logic sync, input logic expect_valid);
        logic [7:0] l0;
        l0 = sync ? 8'hBC : w[7:0];
        if (expect_valid) exp_q.push_back(w);
        for (int i = 7; i >= 0; i--)
            step({w[24+i], w[16+i], w[8+i], l0[i]}, 1'b1);
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_missing_valid: pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step(4'($urandom), 1'b1);
        n_cmp++;
        if ({Q3, Q2, Q1, Q0, valid, locked} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_state: Q=%h valid=%b locked=%b required 0/0/0", {Q3, Q2, Q1, Q0}, valid, locked);
        end
        reset = 1'b1;
    endtask

    task automatic test_acquire();
        do_reset();
        send_frame($urandom, 1'b1, 1'b0);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL acquire_locked: locked=%b required 1", locked);
        end
        send_frame(32'h01234567, 1'b0, 1'b1);
        send_frame(32'h89ABCDEF, 1'b0, 1'b1);
        check_drained("acquire");
        n_cmp++;
        if (n_valid != 2) begin
            n_err++;
            $display("FAIL acquire_count: valid_pulses=%0d required 2", n_valid);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(4'hF, 1'b1);
        @(posedge CLK);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({Q3, Q2, Q1, Q0, valid, locked} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_async: Q=%h valid=%b locked=%b required 0/0/0", {Q3, Q2, Q1, Q0}, valid, locked);
        end
        @(negedge CLK);
        reset = 1'b1;
        prev_valid = 1'b0;
    endtask

    task automatic test_sync_refresh();
        logic [31:0] w;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            send_frame($urandom, 1'b1, 1'b0);
            for (int f = 0; f < 16; f++) begin
                w = $urandom;
                if (w[7:0] == 8'hBC) w[7:0] = 8'h3C;
                send_frame(w, 1'b0, 1'b1);
                n_cmp++;
                if (locked !== 1'b1) begin
                    n_err++;
                    $display("FAIL refresh_locked: frame=%0d locked=%b required 1", s * 16 + f, locked);
                end
            end
        end
        check_drained("refresh");
        n_cmp++;
        if (n_valid != 32) begin
            n_err++;
            $display("FAIL refresh_count: valid_pulses=%0d required 32", n_valid);
        end
    endtask

    task automatic test_lock_loss();
        do_reset();
        send_frame($urandom, 1'b1, 1'b0);
        for (int f = 0; f < 16; f++) send_frame(32'hAAAAAAAA, 1'b0, 1'b1);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL loss_before: locked=%b required 1", locked);
        end
        send_frame(32'hAAAAAAAA, 1'b0, 1'b0);
        check_drained("loss");
        n_cmp++;
        if (n_valid != 16) begin
            n_err++;
            $display("FAIL loss_count: valid_pulses=%0d required 16", n_valid);
        end
        n_cmp++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL loss_unlocked: locked=%b required 0", locked);
        end
        n_cmp++;
        if ({Q3, Q2, Q1, Q0} !== 32'hAAAAAAAA) begin
            n_err++;
            $display("FAIL loss_hold: Q=%h required AAAAAAAA", {Q3, Q2, Q1, Q0});
        end
    endtask

    task automatic test_enb_gap();
        logic [31:0] w;
        w = 32'hFEDCBA98;
        do_reset();
        send_frame($urandom, 1'b1, 1'b0);
        exp_q.push_back(w);
        for (int i = 7; i >= 4; i--) step({w[24+i], w[16+i], w[8+i], w[i]}, 1'b1);
        for (int g = 0; g < 5; g++) begin
            step(4'($urandom), 1'b0);
            n_cmp++;
            if (valid !== 1'b0 || locked !== 1'b1) begin
                n_err++;
                $display("FAIL enb_gap: valid=%b locked=%b required 0/1", valid, locked);
            end
        end
        for (int i = 3; i >= 0; i--) step({w[24+i], w[16+i], w[8+i], w[i]}, 1'b1);
        check_drained("enb_gap");
        n_cmp++;
        if (n_valid != 1) begin
            n_err++;
            $display("FAIL enb_gap_count: valid_pulses=%0d required 1", n_valid);
        end
    endtask

    task automatic test_no_false_lock();
        logic [7:0] win;
        logic       b0;
        int         bad;
        do_reset();
        win = 8'h00;
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            b0 = 1'($urandom);
            if ({win[6:0], b0} == 8'hBC) b0 = ~b0;
            win = {win[6:0], b0};
            step({3'($urandom), b0}, 1'b1);
            n_cmp++;
            if (locked !== 1'b0) begin
                n_err++;
                bad++;
                if (bad < 4) $display("FAIL false_lock: cycle=%0d locked=%b required 0", c, locked);
            end
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_reset_mid();
        test_sync_refresh();
        test_lock_loss();
        test_enb_gap();
        test_no_false_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
